// File: rtl/ov7670_frame_writer_pkg.sv
// Shared video definitions for the capture front end and the filter stages:
// RGB565 field positions, default frame buffer geometry and capture FSM states.
package ov7670_frame_writer_pkg;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam int DEF_IMG_WIDTH  = 160;
    localparam int DEF_IMG_HEIGHT = 120;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        CAPTURE,
        END
    } cap_state_t;

endpackage

// File: rtl/ov7670_frame_writer_rgb565_byte_packer.sv
// Pairs consecutive camera bytes into RGB565 pixels; the phase restarts at every
// href low so an odd trailing byte is dropped.
module rgb565_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        href,
    input  logic [7:0]  data,
    output logic        pixel_valid,
    output logic [15:0] pixel
);

    logic       phase;
    logic [7:0] hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
            hi    <= '0;
        end else if (href) begin
            phase <= ~phase;
            if (!phase)
                hi <= data;
        end else begin
            phase <= 1'b0;
        end
    end

    assign pixel_valid = href & phase;
    assign pixel       = {hi, data};

endmodule

// File: rtl/ov7670_frame_writer.sv
// OV7670 capture: assembles RGB565, decimates by DECIM in both axes and writes
// the result linearly into the frame buffer with per-frame done/error pulses.
module ov7670_frame_writer
    import ov7670_frame_writer_pkg::*;
#(
    parameter int SRC_WIDTH  = 640,
    parameter int SRC_HEIGHT = 480,
    parameter int DECIM      = 4,
    parameter int IMG_WIDTH  = SRC_WIDTH / DECIM,
    parameter int IMG_HEIGHT = SRC_HEIGHT / DECIM,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture_en,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [15:0]           wdata,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int XW   = $clog2(SRC_WIDTH + 1);
    localparam int YW   = $clog2(SRC_HEIGHT + 1);
    localparam int CW   = $clog2(NPIX + 1);

    cap_state_t    state, state_nxt;
    logic          in_cap;
    logic          href_q;
    logic [XW-1:0] src_x;
    logic [YW-1:0] src_y;
    logic [CW-1:0] wr_cnt;
    logic          pixel_valid;
    logic [15:0]   pixel;
    logic          keep;

    assign in_cap = (state == CAPTURE);

    rgb565_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .href        (href & in_cap),
        .data        (data),
        .pixel_valid (pixel_valid),
        .pixel       (pixel)
    );

    // Low coordinate bits zero selects one source pixel per DECIM x DECIM block.
    assign keep = in_cap && pixel_valid
               && (src_x < XW'(SRC_WIDTH)) && (src_y < YW'(SRC_HEIGHT))
               && ((src_x & XW'(DECIM - 1)) == '0)
               && ((src_y & YW'(DECIM - 1)) == '0)
               && (wr_cnt < CW'(NPIX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE:       if (capture_en && vsync) state_nxt = WAIT_START;
            WAIT_START: if (!vsync) state_nxt = CAPTURE;
            CAPTURE:    if (vsync) state_nxt = END;
            END: begin
                frame_done = (wr_cnt == CW'(NPIX));
                frame_err  = (wr_cnt != CW'(NPIX));
                state_nxt  = capture_en ? WAIT_START : IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            href_q <= 1'b0;
            src_x  <= '0;
            src_y  <= '0;
            wr_cnt <= '0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            href_q <= href;
            we     <= 1'b0;
            if (state == WAIT_START) begin
                src_x  <= '0;
                src_y  <= '0;
                wr_cnt <= '0;
                waddr  <= '0;
            end else if (in_cap) begin
                if (!href)
                    src_x <= '0;
                else if (pixel_valid && src_x < XW'(SRC_WIDTH))
                    src_x <= src_x + 1'b1;
                if (href_q && !href && src_y < YW'(SRC_HEIGHT))
                    src_y <= src_y + 1'b1;
                // Address is the write count, so it stays linear without a multiplier.
                if (keep) begin
                    we     <= 1'b1;
                    wdata  <= pixel;
                    waddr  <= wr_cnt[ADDR_WIDTH-1:0];
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

endmodule
